// File: rtl/apb_pkg.sv
// Shared APB requester types: FSM state encoding and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter; expired flags the last permitted ACCESS cycle.
module apb_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // Saturates at LIMIT-1 so a stale count can never wrap between transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: command in, one SETUP/ACCESS transfer, held response out.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout
);

    apb_state_e state;
    apb_state_e state_next;
    logic       wait_clear;
    logic       wait_enable;
    logic       timed_out;

    assign cmd_ready   = (state == IDLE);
    assign wait_clear  = (state == SETUP);
    assign wait_enable = (state == ACCESS) && !pready;

    apb_timeout_counter #(
        .LIMIT(TIMEOUT)
    ) u_wait (
        .clk    (pclk),
        .rst    (preset),
        .clear  (wait_clear),
        .enable (wait_enable),
        .expired(timed_out)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready || timed_out) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // pready is tested before timed_out so a late completion beats the timeout.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr   <= cmd_addr;
                        pwrite  <= cmd_write;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (timed_out) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed self-checking bench for apb_requester with a simple wait-state completer.
module tb_apb_requester;

    logic       pclk;
    logic       preset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pready;
    logic       pslverr;
    logic [7:0] prdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;

    int checks = 0;
    int errors = 0;

    int         obs_psel;
    int         obs_pen;
    int         obs_rsp_at;
    logic [7:0] obs_rdata;
    logic       obs_err;
    logic       obs_to;
    logic       obs_psel_at_rsp;
    logic       obs_stable;
    logic       obs_accept_ready;
    logic       obs_idle_after;

    apb_requester #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(16)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Drives one command from IDLE and records what the DUT does until the response is taken.
    // The completer answers after `waits` ACCESS cycles and drives junk outside ACCESS.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input int waits, input logic err, input logic [7:0] rdata);
        int cyc;
        int acc;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b1; prdata = 8'hFF;
        obs_accept_ready = cmd_ready;
        step();
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        cyc = 1; acc = 0;
        obs_psel = 0; obs_pen = 0; obs_rsp_at = -1; obs_stable = 1'b1;
        obs_rdata = 8'hxx; obs_err = 1'bx; obs_to = 1'bx; obs_psel_at_rsp = 1'bx;
        while (obs_rsp_at < 0 && cyc < 40) begin
            if (penable === 1'b1) begin
                pready = (acc >= waits); pslverr = err; prdata = rdata; acc++;
            end else begin
                pready = 1'b1; pslverr = 1'b1; prdata = 8'hFF;
            end
            if (psel === 1'b1) begin
                obs_psel++;
                if (paddr !== addr || pwrite !== wr || pwdata !== wdata) obs_stable = 1'b0;
            end
            if (penable === 1'b1) obs_pen++;
            if (rsp_valid === 1'b1) begin
                obs_rsp_at = cyc; obs_rdata = rsp_rdata; obs_err = rsp_err;
                obs_to = rsp_timeout; obs_psel_at_rsp = psel;
            end
            step();
            cyc++;
        end
        obs_idle_after = cmd_ready;
    endtask

    task automatic test_reset();
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0; rsp_ready = 1'b0;
        repeat (2) step();
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL reset_psel_penable: got %b%b expected 00", psel, penable); end
        checks++; if (paddr !== 8'h00 || pwdata !== 8'h00 || pwrite !== 1'b0) begin errors++; $display("FAIL reset_apb_bus: got paddr=%h pwdata=%h pwrite=%b expected 00 00 0", paddr, pwdata, pwrite); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp: got v=%b e=%b t=%b d=%h expected 0 0 0 00", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        preset = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        step();
        checks++; if (cmd_ready !== 1'b1 || psel !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: got ready=%b psel=%b expected 1 0", cmd_ready, psel); end
    endtask

    task automatic test_read();
        run_txn(1'b0, 8'h02, 8'h11, 0, 1'b0, 8'h5A);
        checks++; if (obs_accept_ready !== 1'b1) begin errors++; $display("FAIL read_accept: got %b expected 1", obs_accept_ready); end
        checks++; if (obs_psel !== 2) begin errors++; $display("FAIL read_psel_cycles: got %0d expected 2", obs_psel); end
        checks++; if (obs_pen !== 1) begin errors++; $display("FAIL read_penable_cycles: got %0d expected 1", obs_pen); end
        checks++; if (obs_rsp_at !== 3) begin errors++; $display("FAIL read_rsp_latency: got %0d expected 3", obs_rsp_at); end
        checks++; if (obs_rdata !== 8'h5A || obs_err !== 1'b0 || obs_to !== 1'b0) begin errors++; $display("FAIL read_rsp: got d=%h e=%b t=%b expected 5a 0 0", obs_rdata, obs_err, obs_to); end
        checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL read_bus_stable: got %b expected 1", obs_stable); end
        checks++; if (obs_idle_after !== 1'b1) begin errors++; $display("FAIL read_back_idle: got %b expected 1", obs_idle_after); end
    endtask

    task automatic test_write_wait();
        run_txn(1'b1, 8'h01, 8'hC3, 3, 1'b0, 8'h77);
        checks++; if (obs_psel !== 5) begin errors++; $display("FAIL write_psel_cycles: got %0d expected 5", obs_psel); end
        checks++; if (obs_pen !== 4) begin errors++; $display("FAIL write_penable_cycles: got %0d expected 4", obs_pen); end
        checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL write_bus_stable: got %b expected 1", obs_stable); end
        checks++; if (obs_rsp_at !== 6) begin errors++; $display("FAIL write_rsp_latency: got %0d expected 6", obs_rsp_at); end
        checks++; if (obs_rdata !== 8'h00 || obs_err !== 1'b0 || obs_to !== 1'b0) begin errors++; $display("FAIL write_rsp: got d=%h e=%b t=%b expected 00 0 0", obs_rdata, obs_err, obs_to); end
    endtask

    task automatic test_slverr();
        run_txn(1'b0, 8'h7E, 8'h00, 1, 1'b1, 8'hA5);
        checks++; if (obs_rsp_at !== 4) begin errors++; $display("FAIL slverr_rsp_latency: got %0d expected 4", obs_rsp_at); end
        checks++; if (obs_rdata !== 8'hA5 || obs_err !== 1'b1 || obs_to !== 1'b0) begin errors++; $display("FAIL slverr_rsp: got d=%h e=%b t=%b expected a5 1 0", obs_rdata, obs_err, obs_to); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 8'h40, 8'h00, 1000, 1'b0, 8'h3C);
        checks++; if (obs_pen !== 16) begin errors++; $display("FAIL timeout_access_cycles: got %0d expected 16", obs_pen); end
        checks++; if (obs_psel !== 17) begin errors++; $display("FAIL timeout_psel_cycles: got %0d expected 17", obs_psel); end
        checks++; if (obs_rsp_at !== 18) begin errors++; $display("FAIL timeout_rsp_latency: got %0d expected 18", obs_rsp_at); end
        checks++; if (obs_rdata !== 8'h00 || obs_err !== 1'b1 || obs_to !== 1'b1) begin errors++; $display("FAIL timeout_rsp: got d=%h e=%b t=%b expected 00 1 1", obs_rdata, obs_err, obs_to); end
        checks++; if (obs_psel_at_rsp !== 1'b0) begin errors++; $display("FAIL timeout_psel_drop: got %b expected 0", obs_psel_at_rsp); end
    endtask

    task automatic test_timeout_edge();
        // Completer answers on the 16th ACCESS cycle, the same cycle the counter expires.
        run_txn(1'b0, 8'h41, 8'h00, 15, 1'b0, 8'hB7);
        checks++; if (obs_pen !== 16) begin errors++; $display("FAIL edge_access_cycles: got %0d expected 16", obs_pen); end
        checks++; if (obs_rdata !== 8'hB7 || obs_err !== 1'b0 || obs_to !== 1'b0) begin errors++; $display("FAIL edge_pready_wins: got d=%h e=%b t=%b expected b7 0 0", obs_rdata, obs_err, obs_to); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] mask;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 8'h5C;
        pready = 1'b1; pslverr = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mask[i] = cmd_ready;
            if (i == 11) cmd_valid = 1'b0;
            step();
        end
        checks++; if (mask !== 12'h111) begin errors++; $display("FAIL b2b_accept_pattern: got %h expected 111", mask); end
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_idle: got ready=%b v=%b expected 1 0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_backpressure();
        logic hold_ok;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; cmd_wdata = 8'h00;
        pready = 1'b1; pslverr = 1'b0; prdata = 8'h66; rsp_ready = 1'b0;
        step();
        cmd_addr = 8'h09;
        step();
        step();
        prdata = 8'h99; pslverr = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 8'h66 ||
                rsp_err !== 1'b0 || rsp_timeout !== 1'b0) hold_ok = 1'b0;
            step();
        end
        checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL bp_rsp_held: got %b expected 1", hold_ok); end
        rsp_ready = 1'b1;
        checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_still_resp: got v=%b ready=%b expected 1 0", rsp_valid, cmd_ready); end
        step();
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_accept_next: got ready=%b v=%b expected 1 0", cmd_ready, rsp_valid); end
        step();
        cmd_valid = 1'b0;
        checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 8'h09) begin errors++; $display("FAIL bp_new_setup: got psel=%b pen=%b paddr=%h expected 1 0 09", psel, penable, paddr); end
        repeat (3) step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_final_idle: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_reset_abort();
        logic quiet;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = 8'h00;
        pready = 1'b0; pslverr = 1'b0; prdata = 8'h12; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        checks++; if (psel !== 1'b1 || penable !== 1'b1) begin errors++; $display("FAIL abort_in_access: got %b%b expected 11", psel, penable); end
        #2 preset = 1'b1;
        #1;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || paddr !== 8'h00) begin errors++; $display("FAIL abort_async_drop: got psel=%b pen=%b paddr=%h expected 0 0 00", psel, penable, paddr); end
        step();
        preset = 1'b0; pready = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle_after: got %b expected 1", cmd_ready); end
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid !== 1'b0 || psel !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL abort_no_rsp: got %b expected 1", quiet); end
        run_txn(1'b0, 8'h10, 8'h00, 0, 1'b0, 8'h81);
        checks++; if (obs_rsp_at !== 3 || obs_rdata !== 8'h81 || obs_err !== 1'b0) begin errors++; $display("FAIL abort_next_cmd: got at=%0d d=%h e=%b expected 3 81 0", obs_rsp_at, obs_rdata, obs_err); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_slverr();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
